// File: rtl/router_port_vc_tx.sv
// ---------------------------------------------------------------------------
// router_port_vc_tx
//
// Transmit side of one router output port.  Several virtual channels (VCs)
// compete for a single physical link.  Each VC owns a credit counter that
// mirrors the free buffer space of the downstream receiver for that VC, so a
// flit is only sent when the receiver is known to have room for it.
//
// A round-robin arbiter picks one eligible VC per cycle.  With PACKET_LOCK=1
// the winner keeps the link from its first flit up to and including its tail
// flit, so packets never interleave on the wire.  With PACKET_LOCK=0 every
// flit is arbitrated on its own.
//
// Parameters
//   FLIT_WIDTH  link flit width in bits
//   NUM_VC      number of virtual channels (1..8)
//   CREDITS     receiver buffer depth per VC (1..15)
//   PACKET_LOCK 1 = hold the grant until the tail flit, 0 = per-flit arbitration
//
// Ports
//   clock       single clock for all logic
//   reset       asynchronous active-high reset
//   src_valid   per-VC flit present
//   src_data    per-VC flit, slice v belongs to VC v
//   src_last    per-VC tail marker
//   src_ready   per-VC accept (combinational, one-hot or zero)
//   tx          link flit valid, one cycle per flit
//   vc_o        VC id of the link flit
//   data_o      link flit
//   credit_i    per-VC credit return pulse
//   credit_cnt  per-VC credit counters, 4 bits each, for observation
//   err_o       sticky credit overflow flag
// ---------------------------------------------------------------------------
module router_port_vc_tx #(
   parameter int FLIT_WIDTH  = 16,
   parameter int NUM_VC      = 2,
   parameter int CREDITS     = 4,
   parameter int PACKET_LOCK = 1,
   localparam int VC_W       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [NUM_VC-1:0]            src_valid,
   input  logic [NUM_VC*FLIT_WIDTH-1:0] src_data,
   input  logic [NUM_VC-1:0]            src_last,
   output logic [NUM_VC-1:0]            src_ready,
   output logic                         tx,
   output logic [VC_W-1:0]              vc_o,
   output logic [FLIT_WIDTH-1:0]        data_o,
   input  logic [NUM_VC-1:0]            credit_i,
   output logic [NUM_VC*4-1:0]          credit_cnt,
   output logic                         err_o
);

   localparam logic [3:0] CNT_MAX = 4'(CREDITS);

   typedef enum logic {
      LINK_FREE,
      LINK_LOCKED
   } lock_state_t;

   lock_state_t           lock_state;
   logic [VC_W-1:0]       lock_vc;
   logic [VC_W-1:0]       last_grant;
   logic [3:0]            cnt [NUM_VC];

   logic [NUM_VC-1:0]     eligible;
   logic [NUM_VC-1:0]     take_vc;
   logic                  grant_found;
   logic [VC_W-1:0]       grant_vc;
   int                    best_dist;
   logic                  transfer;
   logic [FLIT_WIDTH-1:0] sel_data;
   logic                  sel_last;

   // A VC may compete when it has a flit, the receiver has room for it, and
   // the link is either free or already locked to this very VC.  While a
   // packet holds the link every other VC is masked out, which is what turns
   // a starved locked VC into a link stall instead of letting others through.
   always_comb begin
      eligible = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         eligible[v] = src_valid[v] && (cnt[v] != 4'd0) &&
                       ((lock_state == LINK_FREE) || (lock_vc == VC_W'(v)));
      end
   end

   // Round-robin pick.  Each VC is given a distance from the slot just after
   // the previous winner (0 for last_grant+1, NUM_VC-1 for last_grant itself)
   // and the eligible VC with the smallest distance wins.  Working with
   // distances keeps every array index a plain loop constant and behaves the
   // same for VC counts that are not a power of two.
   always_comb begin
      grant_found = 1'b0;
      grant_vc    = '0;
      best_dist   = NUM_VC;
      for (int v = 0; v < NUM_VC; v++) begin
         if (eligible[v] &&
             (((v + NUM_VC - 1 - int'(last_grant)) % NUM_VC) < best_dist)) begin
            best_dist   = (v + NUM_VC - 1 - int'(last_grant)) % NUM_VC;
            grant_found = 1'b1;
            grant_vc    = VC_W'(v);
         end
      end
   end

   // The accept strobe goes only to the winner.  It is held low during reset
   // so an upstream source never believes a flit was taken while the port is
   // being cleared and no flit can be launched.
   always_comb begin
      src_ready = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         src_ready[v] = grant_found && !reset && (grant_vc == VC_W'(v));
      end
   end

   assign take_vc  = src_valid & src_ready;
   assign transfer = |take_vc;

   // Steer the winning VC's flit and tail marker onto shared wires so the
   // registered link stage and the lock logic see a single source.
   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      for (int v = 0; v < NUM_VC; v++) begin
         if (grant_vc == VC_W'(v)) begin
            sel_data = src_data[v*FLIT_WIDTH +: FLIT_WIDTH];
            sel_last = src_last[v];
         end
      end
   end

   // Credit bookkeeping.  A flit sent consumes one credit, a returned credit
   // gives one back, and both in the same cycle cancel out.  A counter can
   // never underflow because a VC at zero is not eligible.  A credit arriving
   // at a full counter means the receiver returned more than was ever sent;
   // the counter stays pinned at CREDITS and the sticky error flag records it.
   // Credits are accepted no matter what the arbiter or lock is doing.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int v = 0; v < NUM_VC; v++) begin
            cnt[v] <= CNT_MAX;
         end
         err_o <= 1'b0;
      end else begin
         for (int v = 0; v < NUM_VC; v++) begin
            if (take_vc[v] && !credit_i[v]) begin
               cnt[v] <= cnt[v] - 4'd1;
            end else if (!take_vc[v] && credit_i[v]) begin
               if (cnt[v] == CNT_MAX) begin
                  err_o <= 1'b1;
               end else begin
                  cnt[v] <= cnt[v] + 4'd1;
               end
            end
         end
      end
   end

   // Link stage and packet lock.  Every accepted flit appears on the link
   // exactly one clock later; idle cycles drop tx but leave vc_o/data_o
   // alone.  The winner becomes the new round-robin reference.  When packet
   // locking is enabled, a non-tail flit pins the link to its VC and the
   // tail flit frees it on the same edge, so the next cycle is arbitrated
   // normally.  Reset abandons any packet in flight and points last_grant at
   // the highest VC so that VC0 is first in line afterwards.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lock_state <= LINK_FREE;
         lock_vc    <= '0;
         last_grant <= VC_W'(NUM_VC - 1);
         tx         <= 1'b0;
         vc_o       <= '0;
         data_o     <= '0;
      end else begin
         tx <= transfer;
         if (transfer) begin
            vc_o       <= grant_vc;
            data_o     <= sel_data;
            last_grant <= grant_vc;
            if (PACKET_LOCK != 0) begin
               case (lock_state)
                  LINK_FREE: begin
                     if (!sel_last) begin
                        lock_state <= LINK_LOCKED;
                        lock_vc    <= grant_vc;
                     end
                  end
                  LINK_LOCKED: begin
                     if (sel_last) begin
                        lock_state <= LINK_FREE;
                     end
                  end
                  default: lock_state <= LINK_FREE;
               endcase
            end
         end
      end
   end

   // Flatten the counters onto the observation port, VC v in nibble v.
   always_comb begin
      credit_cnt = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         credit_cnt[v*4 +: 4] = cnt[v];
      end
   end

endmodule

// File: tb/tb_router_port_vc_tx.sv
// ---------------------------------------------------------------------------
// tb_router_port_vc_tx
//
// Two instances of the port run side by side: instance 0 with packet locking
// (defaults) and instance 1 with per-flit arbitration.  Each has its own
// stimulus.  A behavioural model of both ports, kept as plain integers,
// predicts src_ready and every registered output; a compare process checks
// them on every falling edge.  Directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_router_port_vc_tx;

   localparam int FW = 16;
   localparam int NV = 2;
   localparam int CR = 4;

   logic        clock;
   logic        reset;
   logic [1:0]  srcValid  [2];
   logic [1:0]  srcLast   [2];
   logic [1:0]  creditIn  [2];
   logic [31:0] srcData   [2];
   logic [1:0]  srcReady  [2];
   logic        txOut     [2];
   logic        vcOut     [2];
   logic [15:0] dataOut   [2];
   logic [7:0]  creditCnt [2];
   logic        errOut    [2];

   int checks;
   int passes;

   // Model state: credits per VC, last winner, locked VC (-1 when free) and
   // the registered link outputs.
   int          mCredits [2][2];
   int          mLastGrant [2];
   int          mLockVc [2];
   logic        mTx [2];
   int          mVc [2];
   logic [15:0] mData [2];
   logic        mErr [2];

   router_port_vc_tx #(.FLIT_WIDTH(FW), .NUM_VC(NV), .CREDITS(CR), .PACKET_LOCK(1)) dutLock (
      .clock(clock), .reset(reset),
      .src_valid(srcValid[0]), .src_data(srcData[0]), .src_last(srcLast[0]),
      .src_ready(srcReady[0]), .tx(txOut[0]), .vc_o(vcOut[0]), .data_o(dataOut[0]),
      .credit_i(creditIn[0]), .credit_cnt(creditCnt[0]), .err_o(errOut[0])
   );

   router_port_vc_tx #(.FLIT_WIDTH(FW), .NUM_VC(NV), .CREDITS(CR), .PACKET_LOCK(0)) dutFree (
      .clock(clock), .reset(reset),
      .src_valid(srcValid[1]), .src_data(srcData[1]), .src_last(srcLast[1]),
      .src_ready(srcReady[1]), .tx(txOut[1]), .vc_o(vcOut[1]), .data_o(dataOut[1]),
      .credit_i(creditIn[1]), .credit_cnt(creditCnt[1]), .err_o(errOut[1])
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Which VC the model says wins this cycle, or -1.  Candidates are visited
   // in order starting just after the last winner.
   function automatic int modelGrant(input int inst);
      int g;
      g = -1;
      for (int k = 1; k <= NV; k++) begin
         int cand;
         cand = (mLastGrant[inst] + k) % NV;
         if (g < 0 && srcValid[inst][cand] && mCredits[inst][cand] > 0 &&
             (mLockVc[inst] < 0 || mLockVc[inst] == cand)) begin
            g = cand;
         end
      end
      return g;
   endfunction

   // Model update on each clock edge, cleared by reset.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            for (int v = 0; v < NV; v++) mCredits[i][v] = CR;
            mLastGrant[i] = NV - 1;
            mLockVc[i]    = -1;
            mTx[i]        = 1'b0;
            mVc[i]        = 0;
            mData[i]      = '0;
            mErr[i]       = 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            int g;
            g = modelGrant(i);
            for (int v = 0; v < NV; v++) begin
               int net;
               net = mCredits[i][v] + int'(creditIn[i][v]) - ((g == v) ? 1 : 0);
               if (net > CR) begin
                  net     = CR;
                  mErr[i] = 1'b1;
               end
               mCredits[i][v] = net;
            end
            mTx[i] = (g >= 0);
            if (g >= 0) begin
               mVc[i]        = g;
               mData[i]      = srcData[i][g*FW +: FW];
               mLastGrant[i] = g;
               if (i == 0) mLockVc[i] = srcLast[i][g] ? -1 : g;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Compare every DUT output against the model on each falling edge.
   always @(negedge clock) begin
      for (int i = 0; i < 2; i++) begin
         logic [1:0] expReady;
         logic [7:0] expCnt;
         int g;
         g = modelGrant(i);
         expReady = '0;
         if (!reset && g >= 0) expReady[g] = 1'b1;
         expCnt = '0;
         for (int v = 0; v < NV; v++) expCnt[v*4 +: 4] = 4'(mCredits[i][v]);
         checkOutput($sformatf("src_ready[%0d]", i), 32'(srcReady[i]), 32'(expReady));
         checkOutput($sformatf("tx[%0d]", i), 32'(txOut[i]), 32'(mTx[i]));
         checkOutput($sformatf("vc_o[%0d]", i), 32'(vcOut[i]), 32'(mVc[i]));
         checkOutput($sformatf("data_o[%0d]", i), 32'(dataOut[i]), 32'(mData[i]));
         checkOutput($sformatf("credit_cnt[%0d]", i), 32'(creditCnt[i]), 32'(expCnt));
         checkOutput($sformatf("err_o[%0d]", i), 32'(errOut[i]), 32'(mErr[i]));
      end
   end

   task automatic applyStimulus(input int inst, input logic [1:0] valid,
                                input logic [1:0] last, input logic [1:0] credit,
                                input logic [31:0] data);
      srcValid[inst] = valid;
      srcLast[inst]  = last;
      creditIn[inst] = credit;
      srcData[inst]  = data;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      int txCount;
      int c0;
      int c1;
      checks = 0;
      passes = 0;
      reset  = 1'b0;
      for (int i = 0; i < 2; i++) applyStimulus(i, 2'b00, 2'b00, 2'b00, 32'h0);
      #1 reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("reset credit_cnt", 32'(creditCnt[0]), 32'h44);
      checkOutput("reset tx", 32'(txOut[0]), 32'h0);
      checkOutput("reset err", 32'(errOut[0]), 32'h0);
      reset = 1'b0;

      $display("[TB] scenario 1: VC0 runs out of credits");
      txCount = 0;
      for (int k = 0; k < 5; k++) begin
         applyStimulus(0, 2'b01, 2'b01, 2'b00, {16'h0, 16'hA100 + 16'(k)});
         tick();
         txCount += int'(txOut[0]);
      end
      checkOutput("s1 tx pulses", 32'(txCount), 32'd4);
      checkOutput("s1 vc0 credits", 32'(creditCnt[0][3:0]), 32'd0);
      checkOutput("s1 src_ready", 32'(srcReady[0]), 32'h0);
      applyStimulus(0, 2'b00, 2'b00, 2'b01, 32'h0);
      repeat (4) tick();
      applyStimulus(0, 2'b00, 2'b00, 2'b00, 32'h0);
      tick();

      $display("[TB] scenario 2: per-flit interleave");
      for (int k = 0; k < 6; k++) begin
         logic [1:0] cr;
         cr = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
         applyStimulus(1, 2'b11, 2'b00, cr, {16'hB200 + 16'(k), 16'hA200 + 16'(k)});
         tick();
         checkOutput($sformatf("s2 tx flit %0d", k), 32'(txOut[1]), 32'd1);
         checkOutput($sformatf("s2 vc flit %0d", k), 32'(vcOut[1]), 32'(k % 2));
         c0 = int'(creditCnt[1][3:0]);
         c1 = int'(creditCnt[1][7:4]);
         checkOutput($sformatf("s2 cnt range %0d", k),
                     32'((c0 >= 3 && c0 <= 4 && c1 >= 3 && c1 <= 4) ? 1 : 0), 32'd1);
      end
      applyStimulus(1, 2'b00, 2'b00, 2'b10, 32'h0);
      tick();
      applyStimulus(1, 2'b00, 2'b00, 2'b00, 32'h0);
      tick();

      $display("[TB] scenario 3: locked 3-flit packet");
      applyStimulus(0, 2'b01, 2'b00, 2'b00, {16'hB300, 16'hA300});
      tick();
      checkOutput("s3 vc flit 0", 32'(vcOut[0]), 32'd0);
      applyStimulus(0, 2'b11, 2'b00, 2'b00, {16'hB301, 16'hA301});
      tick();
      checkOutput("s3 vc flit 1", 32'(vcOut[0]), 32'd0);
      checkOutput("s3 data flit 1", 32'(dataOut[0]), 32'hA301);
      applyStimulus(0, 2'b11, 2'b01, 2'b00, {16'hB302, 16'hA302});
      tick();
      checkOutput("s3 vc flit 2", 32'(vcOut[0]), 32'd0);
      applyStimulus(0, 2'b10, 2'b10, 2'b00, {16'hB303, 16'hA303});
      tick();
      checkOutput("s3 tx flit 3", 32'(txOut[0]), 32'd1);
      checkOutput("s3 vc flit 3", 32'(vcOut[0]), 32'd1);
      checkOutput("s3 data flit 3", 32'(dataOut[0]), 32'hB303);
      applyStimulus(0, 2'b00, 2'b00, 2'b11, 32'h0);
      tick();
      applyStimulus(0, 2'b00, 2'b00, 2'b01, 32'h0);
      repeat (2) tick();

      $display("[TB] scenario 4: locked VC stalls the link");
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 2'b01, 2'b00, 2'b00, {16'hB400, 16'hA400 + 16'(k)});
         tick();
      end
      checkOutput("s4 vc0 credits", 32'(creditCnt[0][3:0]), 32'd0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 2'b11, 2'b00, 2'b00, {16'hB410, 16'hA410});
         tick();
         checkOutput($sformatf("s4 stall tx %0d", k), 32'(txOut[0]), 32'd0);
         checkOutput($sformatf("s4 stall ready %0d", k), 32'(srcReady[0]), 32'd0);
      end
      applyStimulus(0, 2'b11, 2'b01, 2'b01, {16'hB420, 16'hA420});
      tick();
      checkOutput("s4 tx at pulse", 32'(txOut[0]), 32'd0);
      applyStimulus(0, 2'b11, 2'b01, 2'b00, {16'hB421, 16'hA421});
      tick();
      checkOutput("s4 tx after pulse", 32'(txOut[0]), 32'd1);
      checkOutput("s4 vc after pulse", 32'(vcOut[0]), 32'd0);
      checkOutput("s4 data after pulse", 32'(dataOut[0]), 32'hA421);
      applyStimulus(0, 2'b10, 2'b10, 2'b00, {16'hB422, 16'hA422});
      tick();
      checkOutput("s4 vc1 after unlock", 32'(vcOut[0]), 32'd1);
      applyStimulus(0, 2'b00, 2'b00, 2'b11, 32'h0);
      tick();
      applyStimulus(0, 2'b00, 2'b00, 2'b01, 32'h0);
      repeat (3) tick();

      $display("[TB] scenario 5: credit overflow and cancel");
      applyStimulus(0, 2'b00, 2'b00, 2'b01, 32'h0);
      tick();
      checkOutput("s5 saturated cnt", 32'(creditCnt[0][3:0]), 32'd4);
      checkOutput("s5 err set", 32'(errOut[0]), 32'd1);
      applyStimulus(0, 2'b01, 2'b01, 2'b00, {16'h0, 16'hA500});
      repeat (2) tick();
      checkOutput("s5 cnt before cancel", 32'(creditCnt[0][3:0]), 32'd2);
      applyStimulus(0, 2'b01, 2'b01, 2'b01, {16'h0, 16'hA501});
      tick();
      checkOutput("s5 cancel tx", 32'(txOut[0]), 32'd1);
      checkOutput("s5 cancel cnt", 32'(creditCnt[0][3:0]), 32'd2);
      applyStimulus(0, 2'b00, 2'b00, 2'b01, 32'h0);
      repeat (2) tick();
      checkOutput("s5 err sticky", 32'(errOut[0]), 32'd1);

      $display("[TB] scenario 6: reset mid-packet");
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 2'b01, 2'b00, 2'b00, {16'h0, 16'hA600 + 16'(k)});
         tick();
      end
      checkOutput("s6 cnt before reset", 32'(creditCnt[0][3:0]), 32'd1);
      #2 reset = 1'b1;
      #1;
      checkOutput("s6 async tx", 32'(txOut[0]), 32'd0);
      checkOutput("s6 async vc", 32'(vcOut[0]), 32'd0);
      checkOutput("s6 async data", 32'(dataOut[0]), 32'd0);
      checkOutput("s6 async err", 32'(errOut[0]), 32'd0);
      checkOutput("s6 async credits", 32'(creditCnt[0]), 32'h44);
      checkOutput("s6 ready in reset", 32'(srcReady[0]), 32'd0);
      applyStimulus(0, 2'b11, 2'b11, 2'b00, {16'hB610, 16'hA610});
      tick();
      checkOutput("s6 no tx in reset", 32'(txOut[0]), 32'd0);
      reset = 1'b0;
      tick();
      checkOutput("s6 first tx", 32'(txOut[0]), 32'd1);
      checkOutput("s6 first vc", 32'(vcOut[0]), 32'd0);
      applyStimulus(0, 2'b00, 2'b00, 2'b00, 32'h0);
      repeat (2) tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/router_port_vc_tx.md
ROUTER_PORT_VC_TX -- requirements
Module: router_port_vc_tx

Interface
REQ-001 The block SHALL have parameter FLIT_WIDTH, default 16: link flit width in bits.
REQ-002 The block SHALL have parameter NUM_VC, default 2: virtual channel count, 1..8.
REQ-003 The block SHALL have parameter CREDITS, default 4: receiver buffer depth per VC, 1..15.
REQ-004 The block SHALL have parameter PACKET_LOCK, default 1: 1 = hold grant until the tail flit, 0 = per-flit arbitration.
REQ-005 The block SHALL have port clock, input, 1: single clock for all logic.
REQ-006 The block SHALL have port reset, input, 1: asynchronous active-high reset.
REQ-007 The block SHALL have port src_valid, input, NUM_VC: bit v means VC v presents a flit.
REQ-008 The block SHALL have port src_data, input, NUM_VC*FLIT_WIDTH: slice v is the flit of VC v.
REQ-009 The block SHALL have port src_last, input, NUM_VC: bit v marks the VC v flit as a packet tail.
REQ-010 The block SHALL have port src_ready, output, NUM_VC: bit v means VC v flit is accepted this cycle.
REQ-011 The block SHALL have port tx, output, 1: link flit valid, one cycle per flit.
REQ-012 The block SHALL have port vc_o, output, max(1,clog2(NUM_VC)): VC id of the link flit.
REQ-013 The block SHALL have port data_o, output, FLIT_WIDTH: link flit.
REQ-014 The block SHALL have port credit_i, input, NUM_VC: a one-cycle pulse on bit v returns one credit for VC v.
REQ-015 The block SHALL have port credit_cnt, output, NUM_VC*4: per-VC credit counters, for observation.
REQ-016 The block SHALL have port err_o, output, 1: sticky flag for credit overflow.

Function
REQ-017 Each VC SHALL have a credit counter; VC v is eligible when src_valid[v]=1 and its counter > 0.
REQ-018 Arbitration SHALL be round-robin: search starts at last_grant+1 (mod NUM_VC), and the first eligible VC wins.
REQ-019 src_ready SHALL be combinational, one-hot or zero, asserted only for the winning VC; transfer = src_valid[v] & src_ready[v].
REQ-020 On transfer, the block SHALL load tx=1, vc_o=v and data_o=slice v on the next clock edge (latency 1); otherwise it SHALL load tx=0 while vc_o and data_o hold their values.
REQ-021 On transfer, the VC v counter SHALL decrement by 1 and last_grant SHALL become v.
REQ-022 On a credit_i[v] pulse, the VC v counter SHALL increment by 1.
REQ-023 A transfer and a credit_i pulse on the same VC in the same cycle SHALL leave that counter unchanged.
REQ-024 A credit_i[v] pulse with the counter at CREDITS and no same-cycle transfer on v SHALL leave the counter saturated at CREDITS and set err_o; err_o SHALL clear only on reset.
REQ-025 A counter at 0 SHALL never decrement; src_ready[v] SHALL stay 0 until a credit returns.
REQ-026 With PACKET_LOCK=1, a transfer with src_last=0 SHALL lock the grant to v, and only v SHALL be eligible while locked.
REQ-027 With PACKET_LOCK=1, a transfer with src_last=1 SHALL release the lock in the same edge.
REQ-028 With PACKET_LOCK=1, a locked VC with 0 credits or src_valid=0 SHALL stall the link; other VCs SHALL NOT be granted.
REQ-029 With PACKET_LOCK=0, src_last SHALL be ignored and flits of different VCs MAY interleave cycle by cycle.
REQ-030 Credit return SHALL be processed regardless of lock and arbitration state.

Reset
REQ-031 Asserting reset at any time SHALL immediately force tx=0, vc_o=0, data_o=0 and err_o=0.
REQ-032 Asserting reset at any time SHALL immediately force all counters to CREDITS, clear the lock and set last_grant=NUM_VC-1, so VC0 has first priority.
REQ-033 A packet in progress when reset asserts SHALL be abandoned; no flit SHALL be emitted while reset=1.

Verification
REQ-034 Scenario 1: defaults, src_valid=01, src_last=1, 5 flits, no credits returned -> 4 tx pulses with vc_o=0, credit_cnt[0]=0, then src_ready=00.
REQ-035 Scenario 2: PACKET_LOCK=0, both VCs valid continuously, credits returned each cycle -> vc_o alternates 0,1,0,1 and each counter stays in 3..4.
REQ-036 Scenario 3: PACKET_LOCK=1, VC0 sends a 3-flit packet (last on flit 3) while VC1 is valid -> 3 consecutive vc_o=0 flits, then vc_o=1.
REQ-037 Scenario 4: PACKET_LOCK=1, VC0 locked with credits exhausted, VC1 valid -> tx=0 and no VC1 grant until credit_i[0] pulses; the VC0 flit follows one cycle after the pulse.
REQ-038 Scenario 5: credit_i=01 at counter=4 -> counter stays 4 and err_o=1; credit_i[0] pulsed together with a VC0 transfer at counter 2 -> counter stays 2.
REQ-039 Scenario 6: reset asserted mid-packet with counters at 1 -> outputs zero asynchronously, counters read 4, and after release VC0 wins first.
